// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and byte-stream
// framing constants used by the loader, its packer and the bench.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CHK,
    RUN,
    FAIL
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 16;
  localparam logic [7:0]  CHK_SEED   = 8'h00;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Little-endian byte-to-word assembler: holds the first three bytes of a word
// and flags completion combinationally when the fourth byte arrives.
module boot_loader_byte_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0] byte_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_reg <= '0;
    end else if (byte_valid) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (byte_valid && (byte_cnt_reg == 2'(gi))) begin
          lane_reg <= byte_data;
        end
      end

      assign word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // The top byte is taken straight from the bus so the word is ready on the
  // same edge that transfers its last byte.
  assign word[31:24] = byte_data;
  assign word_done   = byte_valid && (byte_cnt_reg == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: parses a counted, XOR-checksummed word image from a
// byte stream, writes it into instruction memory and then releases the core.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] word_index_reg;
  logic [CNT_W-1:0] n_hdr;
  logic [7:0]       chk_reg;
  logic             imem_we_reg;
  logic [31:0]      imem_addr_reg;
  logic [31:0]      imem_wdata_reg;
  logic             xfer;
  logic             data_xfer;
  logic             word_done;
  logic             last_word;
  logic [31:0]      word;

  assign xfer      = rx_valid && rx_ready;
  assign data_xfer = xfer && (state_reg == DATA);
  assign n_hdr     = {rx_data, n_reg[7:0]};
  assign last_word = (word_index_reg == (n_reg - 16'd1));

  boot_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (data_xfer),
    .byte_data  (rx_data),
    .word       (word),
    .word_done  (word_done)
  );

  always_comb begin
    state_next = state_reg;
    rx_ready   = 1'b0;
    core_rst   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      HDR_LO: begin
        rx_ready = 1'b1;
        if (xfer) state_next = HDR_HI;
      end
      HDR_HI: begin
        rx_ready = 1'b1;
        if (xfer) begin
          if (n_hdr == '0)                    state_next = CHK;
          else if ({16'd0, n_hdr} > DEPTH_W) state_next = FAIL;
          else                                state_next = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (word_done && last_word) state_next = CHK;
      end
      CHK: begin
        rx_ready = 1'b1;
        if (xfer) state_next = (rx_data == chk_reg) ? RUN : FAIL;
      end
      RUN: begin
        core_rst = 1'b1;
        done     = 1'b1;
      end
      FAIL: begin
        err = 1'b1;
      end
      default: state_next = HDR_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= HDR_LO;
      n_reg          <= '0;
      word_index_reg <= '0;
      chk_reg        <= CHK_SEED;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= BASE_ADDR;
      imem_wdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      imem_we_reg <= word_done;
      if (xfer && (state_reg == HDR_LO)) n_reg <= {8'd0, rx_data};
      if (xfer && (state_reg == HDR_HI)) n_reg <= n_hdr;
      if (data_xfer) chk_reg <= chk_reg ^ rx_data;
      // The strobe lands one cycle after the last byte, which is never later
      // than the checksum transfer, so the core cannot be released early.
      if (word_done) begin
        imem_wdata_reg <= word;
        imem_addr_reg  <= BASE_ADDR + (32'(word_index_reg) << 2);
        word_index_reg <= word_index_reg + 16'd1;
      end
    end
  end

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed scenarios plus randomized
// images compared against a queue-based model of the stream format.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] img[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          early_release = 0;

  boot_loader #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Every strobe seen mid-cycle is one memory write; a released core at that
  // point means the image was handed over before it was fully written.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      if (core_rst !== 1'b0) early_release++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] img_xor();
    logic [7:0] x = CHK_SEED;
    foreach (img[i]) begin
      for (int b = 0; b < 4; b++) x ^= img[i][8*b +: 8];
    end
    return x;
  endfunction

  task automatic reset_checks();
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, BASE_ADDR);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rx_ready", rx_ready, 1);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    @(posedge clk); #1;
    reset_checks();
    rst = 1'b1;
  endtask

  // gap_mode: 0 back-to-back, 1 exactly one idle cycle, 2 random 0..2 idles
  task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit word_end);
    int n_idle;
    n_idle = (gap_mode == 2) ? int'($urandom_range(2, 0)) : gap_mode;
    repeat (n_idle) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (word_end) chk("strobe_after_word", imem_we, 1);
  endtask

  task automatic load_and_check(input int n, input logic [7:0] chk_byte, input int gap_mode);
    int         base_w;
    int         base_e;
    int         got;
    int         exp_writes;
    bit         expect_run;
    logic [7:0] x;
    base_w = wr_addr.size();
    base_e = early_release;
    x      = img_xor();
    send_byte(n[7:0], gap_mode, 1'b0);
    send_byte(n[15:8], gap_mode, 1'b0);
    if (n > int'(DEPTH)) begin
      expect_run = 1'b0;
      exp_writes = 0;
    end else begin
      foreach (img[i]) begin
        for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], gap_mode, b == 3);
      end
      send_byte(chk_byte, gap_mode, 1'b0);
      expect_run = (chk_byte == x);
      exp_writes = n;
    end
    chk("end_core_rst", core_rst, expect_run);
    chk("end_done", done, expect_run);
    chk("end_err", err, !expect_run);
    chk("end_rx_ready", rx_ready, 0);
    rx_valid = 1'b1;
    repeat (3) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    chk("hold_done", done, expect_run);
    chk("hold_err", err, !expect_run);
    got = wr_addr.size() - base_w;
    chk("write_count", got, exp_writes);
    for (int i = 0; i < exp_writes && i < got; i++) begin
      chk("write_addr", wr_addr[base_w + i], BASE_ADDR + 32'(4 * i));
      chk("write_data", wr_data[base_w + i], img[i]);
    end
    chk("early_release", early_release - base_e, 0);
    $display("load n=%0d chk=%h model_chk=%h gaps=%0d writes=%0d done=%0b err=%0b",
             n, chk_byte, x, gap_mode, got, done, err);
  endtask

  initial begin
    int          n;
    int          r;
    int          base_w;
    logic [7:0]  cb;

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b1;

    // Two-word image, good then corrupted checksum
    img = '{32'h0000_0013, 32'h0050_0093};
    load_and_check(2, img_xor(), 0);
    do_reset();
    load_and_check(2, img_xor() ^ 8'h01, 0);

    // Empty image
    do_reset();
    img.delete();
    load_and_check(0, 8'h00, 0);
    do_reset();
    load_and_check(0, 8'h01, 0);

    // Oversized header
    do_reset();
    load_and_check(int'(DEPTH) + 1, 8'h00, 0);

    // Reset after two bytes of the second word abandons the load
    do_reset();
    img = '{32'hDEAD_BEEF, 32'h1234_5678};
    base_w = wr_addr.size();
    send_byte(8'd2, 0, 1'b0);
    send_byte(8'd0, 0, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 0, b == 3);
    send_byte(img[1][7:0], 0, 1'b0);
    send_byte(img[1][15:8], 0, 1'b0);
    rst      = 1'b0;
    rx_valid = 1'b1;
    rx_data  = img[1][23:16];
    @(posedge clk); #1;
    reset_checks();
    rst      = 1'b1;
    rx_valid = 1'b0;
    chk("midload_writes", wr_addr.size() - base_w, 1);
    load_and_check(2, img_xor(), 0);

    // Reset coinciding with a word's final byte must not produce a strobe
    do_reset();
    base_w = wr_addr.size();
    send_byte(8'd2, 0, 1'b0);
    send_byte(8'd0, 0, 1'b0);
    for (int b = 0; b < 3; b++) send_byte(img[0][8*b +: 8], 0, 1'b0);
    rst      = 1'b0;
    rx_valid = 1'b1;
    rx_data  = img[0][31:24];
    @(posedge clk); #1;
    chk("rst_edge_no_strobe", imem_we, 0);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_edge_writes", wr_addr.size() - base_w, 0);

    // Three-word image with valid toggling every cycle
    do_reset();
    img = '{32'hA5A5_0001, 32'h0F0F_F0F0, 32'h8000_0007};
    load_and_check(3, img_xor(), 1);

    // Randomized images
    for (int it = 0; it < 24; it++) begin
      do_reset();
      img.delete();
      r = int'($urandom_range(9, 0));
      if (r == 0)      n = 0;
      else if (r == 9) n = int'($urandom_range(65535, DEPTH + 1));
      else             n = int'($urandom_range(DEPTH, 1));
      if (n <= int'(DEPTH)) begin
        for (int i = 0; i < n; i++) img.push_back($urandom);
      end
      cb = img_xor();
      if ($urandom_range(3, 0) == 0) cb ^= 8'($urandom_range(255, 1));
      load_and_check(n, cb, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
